// File: rtl/sop_lut_eval_if.sv
// Stimulus/result bundle for sop_lut_eval: evaluate, serial mask load and sweep handshakes.
// The inv signal exists only when SOP_INVERT_EN is defined.
interface sop_lut_eval_if #(
    parameter int N_IN = 4
);
    logic [N_IN-1:0] in_vec;
    logic            in_valid;
    logic            load_en;
    logic            load_bit;
    logic            sweep_start;
`ifdef SOP_INVERT_EN
    logic            inv;
`endif
    logic            f_out;
    logic            f_valid;
    logic            busy;
    logic            load_done;
    logic            load_err;
    logic            sweep_done;
    logic [N_IN:0]   ones_count;

    modport master (
        output in_vec, in_valid, load_en, load_bit, sweep_start,
`ifdef SOP_INVERT_EN
        output inv,
`endif
        input  f_out, f_valid, busy, load_done, load_err, sweep_done, ones_count
    );

    modport slave (
        input  in_vec, in_valid, load_en, load_bit, sweep_start,
`ifdef SOP_INVERT_EN
        input  inv,
`endif
        output f_out, f_valid, busy, load_done, load_err, sweep_done, ones_count
    );
endinterface

// File: rtl/sop_lut_eval.sv
// Registered N_IN-input sum-of-products evaluator with a serially loaded minterm mask and a
// minterm-count sweep engine. Define SOP_INVERT_EN to add the inv input (POS view).
module sop_lut_eval #(
    parameter int                    N_IN       = 4,
    parameter logic [(1<<N_IN)-1:0]  RESET_MASK = 16'hC4F4
) (
    input  logic          clk,
    input  logic          rst,
    sop_lut_eval_if.slave bus
);
    localparam int D = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST = N_IN'(D - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t          state_q, state_d;
    logic [D-1:0]    mask_q, mask_d;
    logic [D-1:0]    shadow_q, shadow_d;
    logic [N_IN-1:0] bit_cnt_q, bit_cnt_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   acc_q, acc_d;
    logic [N_IN:0]   ones_count_q, ones_count_d;
    logic            inv_q, inv_d;
    logic            f_out_q, f_out_d;
    logic            f_valid_q, f_valid_d;
    logic            load_done_q, load_done_d;
    logic            load_err_q, load_err_d;
    logic            sweep_done_q, sweep_done_d;

    logic            inv_in;
    logic [D-1:0]    shifted;
    logic [N_IN:0]   acc_next;

`ifdef SOP_INVERT_EN
    assign inv_in = bus.inv;
`else
    assign inv_in = 1'b0;
`endif

    assign shifted  = {shadow_q[D-2:0], bus.load_bit};
    // The latched inv turns the sweep into a zero counter for the whole pass.
    assign acc_next = acc_q + {{N_IN{1'b0}}, mask_q[idx_q] ^ inv_q};

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        shadow_d     = shadow_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        ones_count_d = ones_count_q;
        inv_d        = inv_q;
        f_out_d      = f_out_q;
        f_valid_d    = 1'b0;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
        sweep_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    shadow_d  = shifted;
                    bit_cnt_d = N_IN'(1);
                    state_d   = LOAD;
                end else if (bus.sweep_start) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    inv_d   = inv_in;
                    state_d = SWEEP;
                end else if (bus.in_valid) begin
                    f_out_d   = mask_q[bus.in_vec] ^ inv_in;
                    f_valid_d = 1'b1;
                end
            end
            LOAD: begin
                if (bus.load_en) begin
                    if (bit_cnt_q == LAST) begin
                        mask_d      = shifted;
                        shadow_d    = '0;
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        shadow_d  = shifted;
                        bit_cnt_d = bit_cnt_q + N_IN'(1);
                    end
                end else begin
                    // A gap in the strobe aborts the load; the live mask is untouched.
                    shadow_d   = '0;
                    load_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            SWEEP: begin
                if (idx_q == LAST) begin
                    ones_count_d = acc_next;
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                    acc_d = acc_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= RESET_MASK;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            ones_count_q <= '0;
            inv_q        <= 1'b0;
            f_out_q      <= 1'b0;
            f_valid_q    <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            shadow_q     <= shadow_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            ones_count_q <= ones_count_d;
            inv_q        <= inv_d;
            f_out_q      <= f_out_d;
            f_valid_q    <= f_valid_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign bus.f_out      = f_out_q;
    assign bus.f_valid    = f_valid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.ones_count = ones_count_q;
endmodule

// File: tb/tb_sop_lut_eval.sv
// Self-checking bench for sop_lut_eval: directed scenarios plus randomized transactions
// compared against a transaction-level model of the mask and minterm count.
module tb_sop_lut_eval;
    localparam int N_IN = 4;
    localparam int D    = 1 << N_IN;
    localparam logic [D-1:0] RST_MASK = 16'hC4F4;

    logic clk;
    logic rst;
    logic inv_drv;
    int   n_cmp;
    int   n_err;

    logic [D-1:0] mdl_mask;
    int           mdl_cnt;

    sop_lut_eval_if #(.N_IN(N_IN)) bus ();

    sop_lut_eval #(.N_IN(N_IN), .RESET_MASK(RST_MASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef SOP_INVERT_EN
    assign bus.inv = inv_drv;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic eff_inv(input logic iv);
`ifdef SOP_INVERT_EN
        return iv;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_vec      = '0;
        bus.in_valid    = 1'b0;
        bus.load_en     = 1'b0;
        bus.load_bit    = 1'b0;
        bus.sweep_start = 1'b0;
        inv_drv         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_mask = RST_MASK;
        mdl_cnt  = 0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_f_out", bus.f_out, 0);
        chk("rst_pulses", {bus.f_valid, bus.load_done, bus.load_err, bus.sweep_done}, 0);
        chk("rst_ones", bus.ones_count, 0);
    endtask

    task automatic do_eval(input logic [N_IN-1:0] v, input logic iv);
        @(negedge clk);
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        inv_drv      = iv;
        @(negedge clk);
        bus.in_valid = 1'b0;
        inv_drv      = 1'b0;
        chk("eval_valid", bus.f_valid, 1);
        chk("eval_f_out", bus.f_out, mdl_mask[v] ^ eff_inv(iv));
        chk("eval_ones_hold", bus.ones_count, mdl_cnt);
    endtask

    // Feeds the first n bits of m, MSB first; n < D must abort with load_err.
    task automatic do_load(input logic [D-1:0] m, input int n, input logic also_sweep);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 1) chk("load_busy", bus.busy, 1);
            bus.load_en     = 1'b1;
            bus.load_bit    = m[D-1-i];
            bus.sweep_start = also_sweep && (i == 0);
        end
        @(negedge clk);
        bus.load_en     = 1'b0;
        bus.sweep_start = 1'b0;
        if (n == D) begin
            mdl_mask = m;
            chk("load_done", bus.load_done, 1);
            chk("load_no_err", bus.load_err, 0);
            @(negedge clk);
            chk("load_done_pulse", bus.load_done, 0);
            chk("load_idle", {bus.busy, bus.sweep_done}, 0);
        end else begin
            chk("abort_pending", bus.load_err, 0);
            @(negedge clk);
            chk("load_err", bus.load_err, 1);
            chk("abort_no_done", bus.load_done, 0);
            @(negedge clk);
            chk("load_err_pulse", bus.load_err, 0);
            chk("abort_idle", bus.busy, 0);
        end
    endtask

    // Drives junk requests during the sweep; none of them may take effect.
    task automatic do_sweep(input logic iv, input logic junk);
        int   k;
        logic fv_seen;
        logic busy_first;
        int   exp;
        @(negedge clk);
        bus.sweep_start = 1'b1;
        inv_drv         = iv;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        inv_drv         = 1'b0;
        k = 1;
        fv_seen = bus.f_valid;
        busy_first = bus.busy;
        while (!bus.sweep_done && k <= 4 * D) begin
            if (junk && k < D) begin
                bus.in_valid    = 1'(($urandom() & 1));
                bus.in_vec      = N_IN'($urandom());
                bus.load_en     = 1'(($urandom() & 1));
                bus.load_bit    = 1'(($urandom() & 1));
                bus.sweep_start = 1'(($urandom() & 1));
                inv_drv         = 1'(($urandom() & 1));
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            k++;
            fv_seen |= bus.f_valid;
        end
        idle_inputs();
        exp = eff_inv(iv) ? D - $countones(mdl_mask) : $countones(mdl_mask);
        mdl_cnt = exp;
        chk("sweep_busy", busy_first, 1);
        chk("sweep_latency", k - 1, D);
        chk("sweep_ones", bus.ones_count, exp);
        chk("sweep_no_fvalid", fv_seen, 0);
        chk("sweep_end_busy", bus.busy, 0);
        @(negedge clk);
        chk("sweep_done_pulse", bus.sweep_done, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        mdl_mask = RST_MASK;
        mdl_cnt  = 0;

        do_reset();
        do_eval(4'b0100, 1'b0);
        do_eval(4'b0000, 1'b0);

        // back-to-back evaluations with in_valid held high
        @(negedge clk);
        bus.in_vec = 4'd2; bus.in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_first", {bus.f_valid, bus.f_out}, {1'b1, RST_MASK[2]});
        bus.in_vec = 4'd15;
        @(negedge clk);
        chk("b2b_second", {bus.f_valid, bus.f_out}, {1'b1, RST_MASK[15]});
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("f_valid_pulse", bus.f_valid, 0);

        do_sweep(1'b0, 1'b0);
        chk("reset_mask_count", mdl_cnt, 8);

        do_load({D{1'b1}}, D, 1'b0);
        do_sweep(1'b0, 1'b0);
        do_eval(4'b0000, 1'b0);

        do_reset();
        do_load(16'h1234, 5, 1'b0);
        do_sweep(1'b0, 1'b0);

        // reset partway through a sweep of an all-zero mask
        do_load('0, D, 1'b0);
        @(negedge clk);
        bus.sweep_start = 1'b1;
        @(negedge clk);
        bus.sweep_start = 1'b0;
        repeat (6) @(negedge clk);
        do_reset();
        do_sweep(1'b0, 1'b0);

        do_load(16'h0F0F, D, 1'b1);
        do_eval(4'd8, 1'b0);

`ifdef SOP_INVERT_EN
        do_reset();
        do_sweep(1'b1, 1'b0);
        do_eval(4'b0000, 1'b1);
`endif

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: do_eval(N_IN'($urandom()), 1'(($urandom() & 1)));
                1: do_load(D'($urandom()), D, 1'(($urandom() & 1)));
                2: do_load(D'($urandom()), $urandom_range(1, D - 1), 1'b0);
                default: do_sweep(1'(($urandom() & 1)), 1'b1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
